logic_ex_stage: RTL and testbench
=================================

LOGIC_EX_STAGE -- requirements
Module: logic_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have parameter TAGW, default 5, the destination-register tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset: asynchronous assertion, active-low.
REQ-005 SHALL have port flush, input, 1, synchronous pipeline flush.
REQ-006 SHALL have port in_valid, input, 1, the decode-side request is valid.
REQ-007 SHALL have port in_ready, output, 1, the stage can accept a request.
REQ-008 SHALL have ports in_a and in_b, input, WIDTH each, the operands.
REQ-009 SHALL have port in_op, input, 3, the opcode.
REQ-010 SHALL have port in_tag, input, TAGW, the tag passed through with the result.
REQ-011 SHALL have port out_valid, output, 1, a result is presented.
REQ-012 SHALL have port out_ready, input, 1, the MEM side takes the result.
REQ-013 SHALL have ports out_result (WIDTH), out_tag (TAGW), out_zero, out_carryout, out_overflow and out_illegal (1 each), all outputs.
REQ-014 SHALL have port op_count, output, 16, the count of accepted requests.

Function
REQ-015 Opcodes SHALL be: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110/111 illegal.
REQ-016 An illegal opcode SHALL give result 0 and illegal=1; it still occupies a slot and is delivered.
REQ-017 out_zero SHALL be 1 exactly when the stored result is all zeros, including for illegal ops.
REQ-018 out_carryout and out_overflow SHALL be constant 0.
REQ-019 An accept SHALL occur when in_valid and in_ready are both 1 and flush is 0.
REQ-020 A delivery SHALL occur when out_valid and out_ready are both 1.
REQ-021 The result, computed combinationally from the inputs, SHALL be captured at the accept.
REQ-022 Latency SHALL be 1 cycle: the earliest out_valid is the cycle after the accept.
REQ-023 Buffering SHALL be 2 entries (head plus skid), in-order, with a state machine EMPTY/ONE/TWO.
REQ-024 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it is a registered function of state only.
REQ-025 out_valid SHALL be 1 in ONE and TWO; the out_* fields come from the head entry.
REQ-026 Transitions SHALL be:
- EMPTY + accept -> ONE.
- ONE + accept without delivery -> TWO.
- ONE + delivery without accept -> EMPTY.
- ONE + accept and delivery -> ONE, head replaced by the new entry.
- TWO + delivery -> ONE, skid entry moves to head.
REQ-027 out_* fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 flush SHALL move the state to EMPTY next cycle and discard both entries plus any same-cycle in_valid; a same-cycle delivery still counts as delivered.
REQ-029 op_count SHALL increment on each accept, saturate at 0xFFFF, and be unaffected by flush.

Reset
REQ-030 While reset_n=0 the state SHALL be EMPTY, with out_valid=0, in_ready=0, op_count=0.
REQ-031 While reset_n=0, out_result, out_tag, out_zero, out_illegal, out_carryout and out_overflow SHALL all be 0.
REQ-032 in_ready SHALL rise the first clock after reset_n deasserts.
REQ-033 A reset mid-transfer SHALL drop all entries with no partial delivery.

Configuration
REQ-034 Macro LOGIC_EX_XOR_EN SHALL control XOR support.
REQ-035 With LOGIC_EX_XOR_EN defined, 100/101 SHALL compute XOR/XNOR.
REQ-036 Without LOGIC_EX_XOR_EN, 100/101 SHALL be treated as illegal per REQ-016, and no XOR logic is synthesized.

Structure
REQ-037 The shared package logic_ex_pkg SHALL hold:
- opcode constants OP_AND..OP_XNOR;
- the state encoding EMPTY/ONE/TWO;
- the entry record {result, tag, zero, illegal}.
REQ-038 One sub-module, logic_ex_slice, SHALL be the combinational WIDTH-bit op evaluator; the buffer, state machine and counter SHALL live in logic_ex_stage.

Verification
REQ-039 A bench SHALL cover a single op: a=0xF0F0_1234, b=0x0FF0_FFFF, op=AND, out_ready=1 -> next cycle out_valid=1, result=0x00F0_1234, zero=0.
REQ-040 A bench SHALL cover backpressure: out_ready=0 with three requests offered -> two accepted, then in_ready=0; results held stable; out_ready=1 drains them in order, tags 1 then 2.
REQ-041 A bench SHALL cover simultaneous accept and delivery in ONE: state stays ONE, out_tag updates next cycle, op_count +1.
REQ-042 A bench SHALL cover flush in TWO with in_valid=1 -> next cycle out_valid=0 and in_ready=1, op_count unchanged by the dropped request.
REQ-043 A bench SHALL cover illegal and XOR ops: op=111 -> result 0, zero=1, illegal=1; op=100 with a=b=0xFFFF_FFFF gives result 0, zero=1, illegal=0 with LOGIC_EX_XOR_EN and illegal=1 without it.
REQ-044 A bench SHALL cover reset_n pulled low in TWO -> outputs 0 immediately, op_count=0; op_count saturation at 0xFFFF after 65536+ accepts.

Source files
------------

// File: rtl/logic_ex_pkg.sv
// Shared definitions for the logic execute stage: opcodes, buffer states,
// the buffered entry record and the saturating counter helper.
package logic_ex_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Record fields are sized for the widest supported configuration; a
  // stage instance only ever drives the low WIDTH / TAGW bits.
  localparam int unsigned RESULT_W_MAX = 64;
  localparam int unsigned TAG_W_MAX    = 16;

  typedef struct packed {
    logic [RESULT_W_MAX-1:0] result;
    logic [TAG_W_MAX-1:0]    tag;
    logic                    zero;
    logic                    illegal;
  } entry_t;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/logic_ex_slice.sv
// Combinational WIDTH-bit logic-op evaluator.
// XOR/XNOR are only built when LOGIC_EX_XOR_EN is defined; otherwise they decode as illegal.
module logic_ex_slice
  import logic_ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             illegal_o
);

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] or_w;
`ifdef LOGIC_EX_XOR_EN
  logic [WIDTH-1:0] xor_w;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign and_w[gi] = a_i[gi] & b_i[gi];
    assign or_w[gi]  = a_i[gi] | b_i[gi];
`ifdef LOGIC_EX_XOR_EN
    assign xor_w[gi] = a_i[gi] ^ b_i[gi];
`endif
  end

  // Each legal op is a base function optionally inverted; illegal ops force zero.
  logic [WIDTH-1:0] base;
  logic             invert;

  always_comb begin
    base      = '0;
    invert    = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_AND:  base = and_w;
      OP_NAND: begin base = and_w; invert = 1'b1; end
      OP_OR:   base = or_w;
      OP_NOR:  begin base = or_w;  invert = 1'b1; end
`ifdef LOGIC_EX_XOR_EN
      OP_XOR:  base = xor_w;
      OP_XNOR: begin base = xor_w; invert = 1'b1; end
`endif
      default: illegal_o = 1'b1;
    endcase
    if (illegal_o) begin
      result_o = '0;
    end else if (invert) begin
      result_o = ~base;
    end else begin
      result_o = base;
    end
  end

endmodule

// File: rtl/logic_ex_stage.sv
// Logic execute stage: one-cycle op evaluation into a two-entry in-order buffer
// (head + skid) with flush and a saturating accept counter. Macro: LOGIC_EX_XOR_EN.
module logic_ex_stage
  import logic_ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_zero,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [15:0]      op_count
);

  logic [WIDTH-1:0] slice_result;
  logic             slice_illegal;

  logic_ex_slice #(
    .WIDTH(WIDTH)
  ) u_slice (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_op),
    .result_o (slice_result),
    .illegal_o(slice_illegal)
  );

  entry_t new_entry;

  always_comb begin
    new_entry                     = '0;
    new_entry.result[WIDTH-1:0]   = slice_result;
    new_entry.tag[TAGW-1:0]       = in_tag;
    new_entry.zero                = (slice_result == '0);
    new_entry.illegal             = slice_illegal;
  end

  state_e      state_q;
  entry_t      head_q;
  entry_t      skid_q;
  logic        in_ready_q;
  logic [15:0] count_q;

  logic accept;
  logic deliver;

  assign accept  = in_valid & in_ready_q & ~flush;
  assign deliver = out_valid & out_ready;

  // in_ready is kept as its own register so it stays low during reset and
  // rises on the first clock afterwards, while still tracking state only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      if (accept) begin
        count_q <= sat_inc16(count_q);
      end
      if (flush) begin
        state_q    <= EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: begin
            in_ready_q <= 1'b1;
            if (accept) begin
              head_q  <= new_entry;
              state_q <= ONE;
            end
          end
          ONE: begin
            in_ready_q <= 1'b1;
            if (accept && deliver) begin
              head_q <= new_entry;
            end else if (accept) begin
              skid_q     <= new_entry;
              state_q    <= TWO;
              in_ready_q <= 1'b0;
            end else if (deliver) begin
              state_q <= EMPTY;
            end
          end
          TWO: begin
            in_ready_q <= 1'b0;
            if (deliver) begin
              head_q     <= skid_q;
              state_q    <= ONE;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != EMPTY);
  assign out_result   = head_q.result[WIDTH-1:0];
  assign out_tag      = head_q.tag[TAGW-1:0];
  assign out_zero     = head_q.zero;
  assign out_illegal  = head_q.illegal;
  assign out_carryout = 1'b0;
  assign out_overflow = 1'b0;
  assign op_count     = count_q;

  // Record bits above WIDTH / TAGW are always zero and deliberately unread.
  logic unused_upper;
  assign unused_upper = ^{head_q.result, head_q.tag};

endmodule

// File: tb/tb_logic_ex_stage.sv
// Self-checking bench for logic_ex_stage: directed scenarios plus random traffic
// against a queue-based reference model. Honours LOGIC_EX_XOR_EN like the design.
module tb_logic_ex_stage;

  localparam int WIDTH = 32;
  localparam int TAGW  = 5;

`ifdef LOGIC_EX_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic [TAGW-1:0]  in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic [TAGW-1:0]  out_tag;
  logic             out_zero;
  logic             out_carryout;
  logic             out_overflow;
  logic             out_illegal;
  logic [15:0]      op_count;

  always #5 clk = ~clk;

  logic_ex_stage #(
    .WIDTH(WIDTH),
    .TAGW (TAGW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_zero    (out_zero),
    .out_carryout(out_carryout),
    .out_overflow(out_overflow),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAGW-1:0]  tag;
    logic             ill;
  } exp_t;

  exp_t        model_q[$];
  logic        ready_m = 1'b0;
  logic [15:0] count_m = 16'd0;
  int          checks = 0;
  int          errors = 0;
  bit          verbose = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one logic op from the opcode table.
  function automatic exp_t model_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b, input logic [TAGW-1:0] tag);
    exp_t e;
    e.tag = tag;
    e.ill = 1'b0;
    e.res = '0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = ~(a & b);
      3'd2: e.res = a | b;
      3'd3: e.res = ~(a | b);
      3'd4: if (XOR_EN) e.res = a ^ b;    else e.ill = 1'b1;
      3'd5: if (XOR_EN) e.res = ~(a ^ b); else e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic model_step();
    bit acc;
    bit dlv;
    acc = in_valid && ready_m && !flush;
    dlv = (model_q.size() != 0) && out_ready;
    if (dlv && verbose)
      $display("xfer tag=%0d result=%08h illegal=%0b", model_q[0].tag, model_q[0].res, model_q[0].ill);
    if (flush) begin
      model_q.delete();
    end else begin
      if (dlv) void'(model_q.pop_front());
      if (acc) model_q.push_back(model_op(in_op, in_a, in_b, in_tag));
    end
    if (acc && count_m != 16'hFFFF) count_m = count_m + 16'd1;
    ready_m = (model_q.size() < 2);
  endtask

  task automatic model_reset();
    model_q.delete();
    count_m = 16'd0;
    ready_m = 1'b0;
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, model_q.size() != 0);
    check("in_ready", in_ready, ready_m);
    check("op_count", op_count, count_m);
    check("carryout", out_carryout, 1'b0);
    check("overflow", out_overflow, 1'b0);
    if (model_q.size() != 0) begin
      check("result", out_result, model_q[0].res);
      check("tag", out_tag, model_q[0].tag);
      check("zero", out_zero, model_q[0].res == '0);
      check("illegal", out_illegal, model_q[0].ill);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge happen, then compare.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input logic [TAGW-1:0] tag,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 3'd0, '0, ordy, 1'b0);
  endtask

  task automatic rand_req(input logic [TAGW-1:0] tag, input logic ordy);
    cycle(1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), tag, ordy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_ready"}, in_ready, 1'b0);
    check({tag, "_count"}, op_count, 16'd0);
    check({tag, "_result"}, out_result, '0);
    check({tag, "_tag"}, out_tag, '0);
    check({tag, "_zero"}, out_zero, 1'b0);
    check({tag, "_illegal"}, out_illegal, 1'b0);
  endtask

  logic [WIDTH-1:0] held_res;
  logic [15:0]      count_before;

  initial begin
    // Reset values and first ready
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    idle(1'b0);
    check("rst_release_ready", in_ready, 1'b1);

    // Single AND op
    cycle(1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 5'd3, 1'b1, 1'b0);
    check("single_valid", out_valid, 1'b1);
    check("single_result", out_result, 32'h00F0_1234);
    check("single_zero", out_zero, 1'b0);
    idle(1'b1);

    // Backpressure: three offered, two taken, held, then drained in order
    for (int t = 1; t <= 3; t++) rand_req(5'(t), 1'b0);
    check("bp_ready_low", in_ready, 1'b0);
    check("bp_head_tag1", out_tag, 5'd1);
    held_res = model_q[0].res;
    idle(1'b0);
    check("bp_hold_result", out_result, held_res);
    idle(1'b1);
    check("bp_drain_tag2", out_tag, 5'd2);
    idle(1'b1);
    check("bp_drained", out_valid, 1'b0);

    // Simultaneous accept and delivery in ONE
    rand_req(5'd5, 1'b0);
    count_before = count_m;
    rand_req(5'd7, 1'b1);
    check("sim_tag", out_tag, 5'd7);
    check("sim_valid", out_valid, 1'b1);
    check("sim_ready", in_ready, 1'b1);
    check("sim_count", op_count, count_before + 16'd1);
    idle(1'b1);

    // Flush in TWO with a request offered
    rand_req(5'd11, 1'b0);
    rand_req(5'd12, 1'b0);
    count_before = count_m;
    cycle(1'b1, $urandom, $urandom, 3'd0, 5'd13, 1'b0, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_count", op_count, count_before);

    // Illegal opcode and XOR of equal operands
    cycle(1'b1, $urandom, $urandom, 3'b111, 5'd9, 1'b1, 1'b0);
    check("ill_result", out_result, '0);
    check("ill_zero", out_zero, 1'b1);
    check("ill_flag", out_illegal, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 5'd10, 1'b1, 1'b0);
    check("xor_result", out_result, '0);
    check("xor_zero", out_zero, 1'b1);
    check("xor_illegal", out_illegal, !XOR_EN);
    idle(1'b1);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
            5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    idle(1'b1);
    idle(1'b1);

    // Reset asserted while holding two entries
    rand_req(5'd20, 1'b0);
    rand_req(5'd21, 1'b0);
    check("pre_rst_two", in_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Counter saturation
    verbose = 1'b0;
    repeat (65545) rand_req(5'($urandom), 1'b1);
    check("count_saturated", op_count, 16'hFFFF);
    rand_req(5'd1, 1'b1);
    check("count_stays_saturated", op_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
